// File: rtl/instr_cycle_ctrl.sv
// Instruction-cycle controller: owns the 4-bit sequence counter (SC) and its
// one-hot timing decode. It steps through fetch (T0-T2), decode/indirect (T3),
// execute (T4-T6) and, optionally, an interrupt cycle (RT0-RT2). It drives the
// datapath strobes, and it stalls any memory step until mem_ack is seen.
// Optional feature: define IRQ_EN to enable the interrupt cycle; without it
// irq is unused and r_cyc/int_ack stay 0.
module instr_cycle_ctrl (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [2:0]  ir_op,
  input  logic        ir_i,
  input  logic        hlt,
  input  logic        mem_ack,
  input  logic        irq,
  output logic [15:0] t,
  output logic [7:0]  d,
  output logic        ar_ld,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        exe,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        r_cyc,
  output logic        int_ack,
  output logic        halted
);

  typedef enum logic [1:0] {
    PH_HALT = 2'd0,
    PH_RUN  = 2'd1,
    PH_INT  = 2'd2
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [3:0]  sc_q, sc_d;
  logic [7:0]  d_q, d_d;
  logic        ind_q, ind_d;
  logic        clear_c;
  logic        irq_take;

`ifdef IRQ_EN
  assign irq_take = irq;
  assign r_cyc    = (phase_q == PH_INT);
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_take   = 1'b0;
  assign r_cyc      = 1'b0;
`endif

  assign halted = (phase_q == PH_HALT);
  assign d      = d_q;
  assign t      = halted ? 16'h0000 : (16'h0001 << sc_q);

  // State register: phase, sequence counter, latched opcode decode and I bit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the same pre-edge values regardless of statement order.
    if (res) begin
      phase_q <= PH_HALT;
      sc_q    <= 4'd0;
      d_q     <= 8'h00;
      ind_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sc_q    <= sc_d;
      d_q     <= d_d;
      ind_q   <= ind_d;
    end
  end

  // Next-state and strobe decode from phase/SC, qualified by mem_ack on memory steps.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skipped
    // an assignment would otherwise infer a latch.
    phase_d = phase_q;
    sc_d    = sc_q;
    d_d     = d_q;
    ind_d   = ind_q;
    clear_c = 1'b0;
    ar_ld   = 1'b0;
    ir_ld   = 1'b0;
    pc_inc  = 1'b0;
    exe     = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    int_ack = 1'b0;

    case (phase_q)
      PH_HALT: begin
        if (start) begin
          phase_d = PH_RUN;
          sc_d    = 4'd0;
        end
      end

      PH_RUN: begin
        case (sc_q)
          4'd0: begin
            ar_ld = 1'b1;
            sc_d  = 4'd1;
          end
          4'd1: begin
            mem_rd = 1'b1;
            if (mem_ack) begin
              ir_ld  = 1'b1;
              pc_inc = 1'b1;
              sc_d   = 4'd2;
            end
          end
          4'd2: begin
            ar_ld = 1'b1;
            d_d   = 8'h01 << ir_op;
            ind_d = ir_i;
            sc_d  = 4'd3;
          end
          4'd3: begin
            if (d_q[7]) begin
              // Register-reference: the whole instruction executes here.
              exe = 1'b1;
              if (!ind_q && hlt) begin
                phase_d = PH_HALT;
                sc_d    = 4'd0;
              end else begin
                clear_c = 1'b1;
              end
            end else if (ind_q) begin
              // Indirect: fetch the effective address.
              mem_rd = 1'b1;
              if (mem_ack) begin
                ar_ld = 1'b1;
                sc_d  = 4'd4;
              end
            end else begin
              sc_d = 4'd4;
            end
          end
          4'd4: begin
            exe = 1'b1;
            if (d_q[4]) begin
              clear_c = 1'b1;                       // BUN
            end else if (d_q[3] || d_q[5]) begin
              mem_wr = 1'b1;                        // STA / BSA
              if (mem_ack) begin
                if (d_q[3]) clear_c = 1'b1;
                else        sc_d    = 4'd5;
              end
            end else begin
              mem_rd = 1'b1;                        // AND/ADD/LDA/ISZ
              if (mem_ack) sc_d = 4'd5;
            end
          end
          4'd5: begin
            exe = 1'b1;
            if (d_q[6]) sc_d    = 4'd6;
            else        clear_c = 1'b1;
          end
          4'd6: begin
            exe    = 1'b1;                          // ISZ write-back
            mem_wr = 1'b1;
            if (mem_ack) clear_c = 1'b1;
          end
          default: clear_c = 1'b1;                  // unreachable SC values recover
        endcase
      end

`ifdef IRQ_EN
      PH_INT: begin
        case (sc_q)
          4'd0: begin
            ar_ld = 1'b1;
            sc_d  = 4'd1;
          end
          4'd1: begin
            mem_wr = 1'b1;                          // save return address
            if (mem_ack) sc_d = 4'd2;
          end
          4'd2: begin
            pc_inc  = 1'b1;
            int_ack = 1'b1;
            phase_d = PH_RUN;
            sc_d    = 4'd0;
          end
          default: begin
            phase_d = PH_RUN;
            sc_d    = 4'd0;
          end
        endcase
      end
`endif

      default: begin
        phase_d = PH_HALT;
        sc_d    = 4'd0;
      end
    endcase

    // End of instruction: restart the fetch, or divert into the interrupt cycle.
    if (clear_c) begin
      sc_d = 4'd0;
      if (irq_take) phase_d = PH_INT;
    end
  end

endmodule
